// File: rtl/keypad_pkg.sv
// keypad_pkg: shared encodings and constants for the 4x4 keypad scanner
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;
    localparam logic [3:0] ROW_NONE = 4'b1111;

    typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, REL_DEB} kp_state_e;

    typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_res_e;

    // Number of active-low column bits, saturated at 2 (0 = no hit, 1 = hit, 2 = multi)
    function automatic logic [1:0] low_count(input logic [3:0] c);
        logic [2:0] n;
        n = 3'(!c[0]) + 3'(!c[1]) + 3'(!c[2]) + 3'(!c[3]);
        return (n > 3'd2) ? 2'd2 : n[1:0];
    endfunction

endpackage

// File: rtl/keypad_scan_sync2_bus.sv
// sync2_bus: 4-bit two-flop synchroniser, resets to all ones (keys open)
module sync2_bus
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] s1_q, s2_q;

    // Two-stage capture of the asynchronous column inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= ROW_NONE;
            s2_q <= ROW_NONE;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: row-scans a 4x4 active-low keypad, debounces and reports one key
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int DEB_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam logic [2:0] DEB = 3'(DEB_SCANS);

    logic [3:0] col_s2;
    logic [1:0] phase_q, phase_d, row_idx_q, row_idx_d;
    logic [3:0] row_q, row_d;
    logic [1:0] acc_hits_q, acc_hits_d;
    logic [3:0] acc_code_q, acc_code_d;
    kp_state_e  state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;
    logic       key_down_q, key_down_d;

    logic       sample, scan_end;
    logic [1:0] row_hits, tot_hits, col_idx;
    logic [2:0] hit_sum, cnt_inc;
    logic [3:0] code;
    scan_res_e  res;

    sync2_bus u_sync (
        .clk(clk),
        .rst(rst),
        .d  (col),
        .q  (col_s2)
    );

    // Row timing and per-scan hit accumulation; the last row's sample is folded into the result
    always_comb begin
        sample     = phase_q == 2'd3;
        scan_end   = sample && row_idx_q == 2'd3;
        row_hits   = low_count(col_s2);
        col_idx    = !col_s2[0] ? 2'd0 : !col_s2[1] ? 2'd1 : !col_s2[2] ? 2'd2 : 2'd3;
        hit_sum    = {1'b0, acc_hits_q} + {1'b0, row_hits};
        tot_hits   = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
        code       = (acc_hits_q == 2'd0) ? {row_idx_q, col_idx} : acc_code_q;
        res        = (tot_hits == 2'd0) ? NONE : (tot_hits == 2'd1) ? SINGLE : MULTI;
        phase_d    = phase_q + 2'd1;
        row_idx_d  = sample ? row_idx_q + 2'd1 : row_idx_q;
        row_d      = (phase_q == 2'd0) ? ~(4'b0001 << row_idx_q) : row_q;
        acc_hits_d = scan_end ? 2'd0 : sample ? tot_hits : acc_hits_q;
        acc_code_d = scan_end ? 4'd0 : sample ? code : acc_code_q;
        cnt_inc    = cnt_q + 3'd1;
    end

    // Debounce FSM, advanced only on scan-result edges; key_valid defaults low so it is a single-cycle pulse
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        if (scan_end) begin
            case (state_q)
                IDLE: if (res == SINGLE) begin
                    cand_d = code;
                    if (DEB == 3'd1) begin
                        key_code_d  = code;
                        key_valid_d = 1'b1;
                        key_down_d  = 1'b1;
                        cnt_d       = 3'd0;
                        state_d     = HELD;
                    end else begin
                        cnt_d   = 3'd1;
                        state_d = PRESS_DEB;
                    end
                end
                PRESS_DEB: if (res == SINGLE && code == cand_q) begin
                    if (cnt_inc == DEB) begin
                        key_code_d  = cand_q;
                        key_valid_d = 1'b1;
                        key_down_d  = 1'b1;
                        cnt_d       = 3'd0;
                        state_d     = HELD;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                end
                HELD: if (res == NONE) begin
                    if (DEB == 3'd1) begin
                        key_down_d = 1'b0;
                        cnt_d      = 3'd0;
                        state_d    = IDLE;
                    end else begin
                        cnt_d   = 3'd1;
                        state_d = REL_DEB;
                    end
                end
                REL_DEB: if (res == NONE) begin
                    if (cnt_inc == DEB) begin
                        key_down_d = 1'b0;
                        cnt_d      = 3'd0;
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    cnt_d   = 3'd0;
                    state_d = HELD;
                end
                default: begin
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // All scanner and FSM state, cleared immediately by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q     <= 2'd0;
            row_idx_q   <= 2'd0;
            row_q       <= ROW_NONE;
            acc_hits_q  <= 2'd0;
            acc_code_q  <= 4'd0;
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            row_idx_q   <= row_idx_d;
            row_q       <= row_d;
            acc_hits_q  <= acc_hits_d;
            acc_code_q  <= acc_code_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign row       = row_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule
